// File: rtl/mojo_tx_arbiter.sv
// rtl/mojo_tx_arbiter.sv - round-robin, packet-atomic arbiter for the serial tx byte channel
module mojo_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BYTES = 130
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     abort,
    output logic [7:0]             tx_data,
    output logic                   new_tx_data,
    input  logic                   tx_busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t             state, state_nx;
    logic [PTR_W-1:0]   ptr, ptr_nx, owner, owner_nx, owner_inc, winner, cand;
    logic [7:0]         byte_cnt, byte_cnt_nx, sel_data, tx_data_nx;
    logic               last_q, last_nx, found, new_tx_data_nx;
    logic [NUM_REQ-1:0] grant_nx, ack_nx, done_nx, abort_nx, owner_oh, winner_oh;
    int                 idx;

    // Rotating search starting at ptr; wraps explicitly so non-power-of-2 counts work.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = 0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = PTR_W'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == PTR_W'(i)) sel_data = req_data[8*i +: 8];
        end
    end

    assign owner_inc = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
    assign owner_oh  = NUM_REQ'(1) << owner;
    assign winner_oh = NUM_REQ'(1) << winner;

    always_comb begin
        state_nx       = state;
        ptr_nx         = ptr;
        owner_nx       = owner;
        byte_cnt_nx    = byte_cnt;
        last_nx        = last_q;
        grant_nx       = grant;
        ack_nx         = '0;
        done_nx        = '0;
        abort_nx       = '0;
        tx_data_nx     = tx_data;
        new_tx_data_nx = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nx    = winner_oh;
                    owner_nx    = winner;
                    byte_cnt_nx = 8'd0;
                    state_nx    = OWN;
                end
            end
            OWN: begin
                // A dropped request beats an idle transmitter: nothing is issued.
                if (!req[owner]) begin
                    grant_nx = '0;
                    abort_nx = owner_oh;
                    ptr_nx   = owner_inc;
                    state_nx = IDLE;
                end else if (!tx_busy) begin
                    tx_data_nx     = sel_data;
                    new_tx_data_nx = 1'b1;
                    ack_nx         = owner_oh;
                    last_nx        = req_last[owner];
                    byte_cnt_nx    = byte_cnt + 8'd1;
                    state_nx       = GAP;
                end
            end
            GAP: begin
                // One dead cycle lets tx_busy rise after the strobe before we look at it.
                if (last_q) begin
                    grant_nx = '0;
                    done_nx  = owner_oh;
                    ptr_nx   = owner_inc;
                    state_nx = IDLE;
                end else if (byte_cnt == 8'(MAX_BYTES)) begin
                    grant_nx = '0;
                    abort_nx = owner_oh;
                    ptr_nx   = owner_inc;
                    state_nx = IDLE;
                end else begin
                    state_nx = OWN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            byte_cnt    <= 8'd0;
            last_q      <= 1'b0;
            grant       <= '0;
            ack         <= '0;
            done        <= '0;
            abort       <= '0;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            owner       <= owner_nx;
            byte_cnt    <= byte_cnt_nx;
            last_q      <= last_nx;
            grant       <= grant_nx;
            ack         <= ack_nx;
            done        <= done_nx;
            abort       <= abort_nx;
            tx_data     <= tx_data_nx;
            new_tx_data <= new_tx_data_nx;
        end
    end

endmodule

// File: tb/tb_mojo_tx_arbiter.sv
// tb/tb_mojo_tx_arbiter.sv - self-checking bench for mojo_tx_arbiter
module tb_mojo_tx_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, tx_busy, new_tx_data;
    logic [N-1:0]     req, req_last, grant, ack, done, abort;
    logic [8*N-1:0]   req_data;
    logic [7:0]       tx_data;

    logic [2:0]       req2, last2, grant2, ack2, done2, abort2;
    logic [23:0]      data2;
    logic [7:0]       tx2;
    logic             ntx2, busy2;

    mojo_tx_arbiter #(.NUM_REQ(N), .MAX_BYTES(130)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .grant(grant), .ack(ack), .done(done), .abort(abort),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy)
    );

    mojo_tx_arbiter #(.NUM_REQ(3), .MAX_BYTES(4)) dut_wd (
        .clk(clk), .rst(rst), .req(req2), .req_data(data2), .req_last(last2),
        .grant(grant2), .ack(ack2), .done(done2), .abort(abort2),
        .tx_data(tx2), .new_tx_data(ntx2), .tx_busy(busy2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    task automatic do_reset();
        rst = 1'b1; req = '0; req_last = '0; req_data = '0; tx_busy = 1'b0;
        req2 = '0; last2 = '0; data2 = '0; busy2 = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  last;
        logic        busy;
        logic [3:0]  g, a, d, ab;
        logic        n;
        logic [7:0]  tx;
    } vec_t;
    vec_t tbl[20];

    // Random-phase requester and arbitration model
    int           len[N], pos[N], dly[N], npk[N];
    bit           act[N];
    logic [7:0]   pkt[N][8];
    int           ptr_m, owner_m, stall, win, strobes, p;
    logic [N-1:0] prev_g, cur_req, exp_g;
    bit           prev_ntx, seen;

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            p = (pos[i] < len[i]) ? pos[i] : len[i] - 1;
            req[i]            = act[i];
            req_data[8*i +: 8] = act[i] ? pkt[i][p] : 8'h00;
            req_last[i]       = act[i] && (p == len[i] - 1);
        end
    endtask

    initial begin
        //          req      data          last     b  grant    ack      done     abort    n  tx
        tbl[0]  = '{4'b0001, 32'h00000083, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00};
        tbl[1]  = '{4'b0001, 32'h00000083, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00};
        tbl[2]  = '{4'b0001, 32'h00000083, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00};
        tbl[3]  = '{4'b0001, 32'h00000083, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 8'h83};
        tbl[4]  = '{4'b0001, 32'h00000010, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 8'h83};
        tbl[5]  = '{4'b0001, 32'h00000010, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 8'h10};
        tbl[6]  = '{4'b0001, 32'h000000A5, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 8'h10};
        tbl[7]  = '{4'b0001, 32'h000000A5, 4'b0001, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 8'hA5};
        tbl[8]  = '{4'b0001, 32'h000000A5, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 8'hA5};
        tbl[9]  = '{4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 8'hA5};
        tbl[10] = '{4'b0010, 32'h00005A00, 4'b0000, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 8'hA5};
        tbl[11] = '{4'b0010, 32'h00005A00, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1, 8'h5A};
        tbl[12] = '{4'b0010, 32'h00005A00, 4'b0000, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 8'h5A};
        tbl[13] = '{4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 8'h5A};
        tbl[14] = '{4'b1001, 32'h77000011, 4'b0000, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, 8'h5A};
        tbl[15] = '{4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 8'h5A};
        tbl[16] = '{4'b0001, 32'h00000044, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 8'h5A};
        tbl[17] = '{4'b0001, 32'h00000044, 4'b0001, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 8'h44};
        tbl[18] = '{4'b0001, 32'h00000044, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 8'h44};
        tbl[19] = '{4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 8'h44};

        do_reset();
        chk("reset_state", {grant, ack, done, abort, new_tx_data, tx_data}, 25'd0);
        chk("reset_state_wd", {grant2, ack2, done2, abort2, ntx2, tx2}, 21'd0);

        for (int k = 0; k < 20; k++) begin
            req = tbl[k].req; req_data = tbl[k].data; req_last = tbl[k].last; tx_busy = tbl[k].busy;
            tick();
            chk($sformatf("vec%0d", k), {grant, ack, done, abort, new_tx_data, tx_data},
                {tbl[k].g, tbl[k].a, tbl[k].d, tbl[k].ab, tbl[k].n, tbl[k].tx});
        end

        // Reset in GAP: grant dropped without done/abort, ptr restarts at 0
        do_reset();
        req = 4'b0100; req_data = 32'h00220000; req_last = 4'b0100;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (done != 0) seen = 1;
        end
        chk("rs_done2", {seen, done}, {1'b1, 4'b0100});
        req = 4'b1000; req_data = 32'h33000000; req_last = 4'b0000;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (new_tx_data) seen = 1;
        end
        chk("rs_byte3", {seen, tx_data, grant}, {1'b1, 8'h33, 4'b1000});
        rst = 1'b1; req = 4'b1010;
        tick();
        chk("rs_clear", {grant, ack, done, abort, new_tx_data, tx_data}, 25'd0);
        rst = 1'b0;
        tick();
        chk("rs_ptr0", {grant, done, abort}, {4'b0010, 4'b0000, 4'b0000});

        // Watchdog on a 3-requester, MAX_BYTES=4 instance
        do_reset();
        req2 = 3'b100; data2 = {8'hC1, 8'h00, 8'h0D}; last2 = 3'b000;
        strobes = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (ntx2) strobes++;
            if (done2 != 0) chk("wd_no_done", done2, 3'b000);
            if (abort2 != 0) begin
                seen = 1;
                chk("wd_abort", {abort2, grant2}, {3'b100, 3'b000});
                chk("wd_strobes", strobes, 4);
            end
        end
        chk("wd_seen", seen, 1);
        req2 = 3'b101;
        tick();
        chk("wd_wrap_grant", grant2, 3'b001);
        tick();
        chk("wd_next_byte", {ntx2, ack2, tx2}, {1'b1, 3'b001, 8'h0D});
        req2 = 3'b000;

        // Randomized traffic against the packet-level model
        do_reset();
        ptr_m = 0; owner_m = 0; prev_g = '0; prev_ntx = 0; stall = 0;
        for (int i = 0; i < N; i++) begin
            act[i] = 0; pos[i] = 0; len[i] = 1; npk[i] = 0; dly[i] = $urandom_range(0, 3);
        end
        drive_reqs();
        for (int c = 0; c < 4000; c++) begin
            cur_req = req;
            tick();
            if (prev_g == 0) begin
                exp_g = '0;
                win = -1;
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && cur_req[(ptr_m + k) % N]) win = (ptr_m + k) % N;
                end
                if (win >= 0) exp_g = oh(win);
                chk("rr_grant", grant, exp_g);
                if (win >= 0) owner_m = win;
            end else if (grant != 0) begin
                if (grant != prev_g) chk("grant_hold", grant, prev_g);
            end
            if (new_tx_data || ack != 0) begin
                chk("ack_owner", {new_tx_data, ack}, {1'b1, oh(owner_m)});
                chk("no_back2back", prev_ntx, 0);
                if (pos[owner_m] < len[owner_m]) chk("byte", tx_data, pkt[owner_m][pos[owner_m]]);
                else chk("extra_byte", pos[owner_m], len[owner_m] - 1);
                pos[owner_m]++;
            end
            if (done != 0 || abort != 0) begin
                chk("release", {done, abort, grant}, {oh(owner_m), 4'b0000, 4'b0000});
                chk("pkt_complete", pos[owner_m], len[owner_m]);
                act[owner_m] = 0; dly[owner_m] = $urandom_range(1, 4); npk[owner_m]++;
                ptr_m = (owner_m + 1) % N;
            end
            prev_g = grant; prev_ntx = new_tx_data;
            for (int i = 0; i < N; i++) begin
                if (!act[i]) begin
                    if (dly[i] == 0) begin
                        act[i] = 1; pos[i] = 0; len[i] = $urandom_range(1, 6);
                        for (int b = 0; b < 8; b++) pkt[i][b] = 8'($urandom);
                    end else begin
                        dly[i]--;
                    end
                end
            end
            tx_busy = ($urandom_range(0, 3) == 0);
            drive_reqs();
            if (new_tx_data || cur_req == 0) stall = 0;
            else stall++;
            if (stall > 100) begin
                chk("progress", stall, 0);
                break;
            end
        end
        for (int i = 0; i < N; i++) chk($sformatf("served%0d", i), npk[i] > 10, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
